board_scanner: RTL and testbench

Reads the 10x10 board memory that the initializer fills and streams its contents to downstream consumers such as the renderer and the score logic. It sits on the read port of the board RAM, which has a registered address and one cycle of read latency. On `start` it walks all 100 addresses. It emits the 64 playable cells on a valid/ready stream with 0-based (x, y) coordinates, and tallies piece counts. It also checks border integrity. Cell encoding: 00 empty, 01 player 1, 10 player 2, 11 border.

---
 rtl/board_scanner.sv | 123 ++++++++++++
 tb/tb_board_scanner.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/board_scanner.sv
// board_scanner: walks the 10x10 board RAM and streams the 64 interior cells.
// Also tallies piece counts and flags border/interior encoding errors.
module board_scanner #(
  parameter int CELLS  = 100,
  parameter int ADDR_W = 7
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  input  logic [1:0]        q,
  output logic              cell_valid,
  input  logic              cell_ready,
  output logic [2:0]        cell_x,
  output logic [2:0]        cell_y,
  output logic [1:0]        cell_data,
  output logic [6:0]        count_p1,
  output logic [6:0]        count_p2,
  output logic [6:0]        count_empty,
  output logic              format_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_LATCH,
    S_EMIT,
    S_DONE
  } state_t;

  state_t     state;
  logic [3:0] row;
  logic [3:0] col;
  logic       border;
  logic       last;
  logic       advance;

  assign border = (row == 4'd0) || (row == 4'd9) ||
                  (col == 4'd0) || (col == 4'd9);
  assign last   = (addr == ADDR_W'(CELLS - 1));

  // A cell is finished after LATCH (border) or after its transfer (interior).
  assign advance = ((state == S_LATCH) && border) ||
                   ((state == S_EMIT) && cell_ready);

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= S_IDLE;
      row          <= '0;
      col          <= '0;
      addr         <= '0;
      busy         <= 1'b0;
      done         <= 1'b0;
      cell_valid   <= 1'b0;
      cell_x       <= '0;
      cell_y       <= '0;
      cell_data    <= '0;
      count_p1     <= '0;
      count_p2     <= '0;
      count_empty  <= '0;
      format_error <= 1'b0;
    end else begin
      done <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            count_p1     <= '0;
            count_p2     <= '0;
            count_empty  <= '0;
            format_error <= 1'b0;
            addr         <= '0;
            row          <= '0;
            col          <= '0;
            busy         <= 1'b1;
            state        <= S_READ;
          end
        end
        S_READ: state <= S_LATCH;
        S_LATCH: begin
          if (border) begin
            if (q != 2'b11) format_error <= 1'b1;
          end else begin
            cell_data  <= q;
            cell_x     <= 3'(col - 4'd1);
            cell_y     <= 3'(row - 4'd1);
            cell_valid <= 1'b1;
            state      <= S_EMIT;
            unique case (q)
              2'b00: count_empty  <= count_empty + 7'd1;
              2'b01: count_p1     <= count_p1 + 7'd1;
              2'b10: count_p2     <= count_p2 + 7'd1;
              2'b11: format_error <= 1'b1;
            endcase
          end
        end
        S_EMIT: begin
          if (cell_ready) cell_valid <= 1'b0;
        end
        S_DONE: state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
      if (advance) begin
        if (last) begin
          state <= S_DONE;
          busy  <= 1'b0;
          done  <= 1'b1;
        end else begin
          addr  <= addr + ADDR_W'(1);
          state <= S_READ;
          if (col == 4'd9) begin
            col <= '0;
            row <= row + 4'd1;
          end else begin
            col <= col + 4'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_board_scanner.sv
// tb_board_scanner: directed scans over preset and random boards.
// Expected stream, counts and timing come from a board-level model.
module tb_board_scanner;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       busy;
  logic       done;
  logic [6:0] addr;
  logic [1:0] q;
  logic       cell_valid;
  logic       cell_ready;
  logic [2:0] cell_x;
  logic [2:0] cell_y;
  logic [1:0] cell_data;
  logic [6:0] count_p1;
  logic [6:0] count_p2;
  logic [6:0] count_empty;
  logic       format_error;

  logic [1:0] mem [100];

  int n_checks = 0;
  int n_fail   = 0;

  board_scanner #(.CELLS(100), .ADDR_W(7)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .addr         (addr),
    .q            (q),
    .cell_valid   (cell_valid),
    .cell_ready   (cell_ready),
    .cell_x       (cell_x),
    .cell_y       (cell_y),
    .cell_data    (cell_data),
    .count_p1     (count_p1),
    .count_p2     (count_p2),
    .count_empty  (count_empty),
    .format_error (format_error)
  );

  always #5 clock = ~clock;

  // Board RAM: registered address, one cycle of read latency.
  always @(posedge clock) q <= mem[addr];

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] out_vec();
    return {24'd0, addr, busy, done, cell_valid, cell_x, cell_y,
            cell_data, count_p1, count_p2, count_empty, format_error};
  endfunction

  task automatic load_pattern();
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        mem[r*10+c] = (r == 0 || r == 9 || c == 0 || c == 9) ? 2'b11 : 2'b00;
    mem[44] = 2'b01;
    mem[55] = 2'b01;
    mem[45] = 2'b10;
    mem[54] = 2'b10;
  endtask

  task automatic load_random(input bit wild);
    for (int r = 0; r < 10; r++)
      for (int c = 0; c < 10; c++)
        if (wild)
          mem[r*10+c] = 2'($urandom_range(0, 3));
        else if (r == 0 || r == 9 || c == 0 || c == 9)
          mem[r*10+c] = 2'b11;
        else
          mem[r*10+c] = 2'($urandom_range(0, 2));
  endtask

  // rmode: 0 ready high, 1 toggling, 2 random.
  task automatic scan(input int rmode, input int rst_cycle,
                      input bit hold_start, input bit poke_start);
    logic [7:0] expq[$];
    int e_p1, e_p2, e_em, n, stalls, idx;
    bit e_fe, got_done, prev_stall;
    logic [7:0] prev;
    bit r;
    e_p1 = 0; e_p2 = 0; e_em = 0; e_fe = 0;
    for (int y = 0; y < 10; y++)
      for (int x = 0; x < 10; x++) begin
        if (y == 0 || y == 9 || x == 0 || x == 9) begin
          if (mem[y*10+x] != 2'b11) e_fe = 1;
        end else begin
          expq.push_back({3'(x-1), 3'(y-1), mem[y*10+x]});
          case (mem[y*10+x])
            2'b00: e_em++;
            2'b01: e_p1++;
            2'b10: e_p2++;
            default: e_fe = 1;
          endcase
        end
      end
    start = 1'b1;
    @(posedge clock); #1;
    if (!hold_start) start = 1'b0;
    n = 1; stalls = 0; idx = 0; got_done = 0; prev_stall = 0; prev = '0;
    check("busy_on_accept", busy, 1'b1);
    check("counts_cleared", {count_p1, count_p2, count_empty, format_error},
          29'd0);
    while (n <= 2000) begin
      if (n == rst_cycle) begin
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("reset_mid_scan", out_vec(), 64'd0);
        return;
      end
      if (poke_start && n == 50) start = 1'b1;
      if (poke_start && n == 51) start = 1'b0;
      if (done) begin
        got_done = 1;
        break;
      end
      if (prev_stall)
        check("stall_stable", {cell_valid, cell_x, cell_y, cell_data},
              {1'b1, prev});
      case (rmode)
        0: r = 1'b1;
        1: r = n[0];
        default: r = 1'($urandom_range(0, 1));
      endcase
      cell_ready = r;
      prev_stall = 0;
      if (cell_valid) begin
        if (r) begin
          check("cell", {cell_x, cell_y, cell_data},
                (idx < expq.size()) ? expq[idx] : 8'hxx);
          idx++;
        end else begin
          stalls++;
          prev_stall = 1;
          prev = {cell_x, cell_y, cell_data};
        end
      end
      @(posedge clock); #1;
      n++;
    end
    check("done_seen", got_done, 1'b1);
    if (!got_done) return;
    check("done_cycle", n, 265 + stalls);
    check("transfers", idx, 64);
    check("busy_at_done", busy, 1'b0);
    check("counts", {count_p1, count_p2, count_empty, format_error},
          {7'(e_p1), 7'(e_p2), 7'(e_em), e_fe});
    cell_ready = 1'b1;
    @(posedge clock); #1;
    check("done_pulse", done, 1'b0);
    check("counts_hold", {count_p1, count_p2, count_empty, format_error},
          {7'(e_p1), 7'(e_p2), 7'(e_em), e_fe});
    if (hold_start) begin
      @(posedge clock); #1;
      start = 1'b0;
      check("rescan_busy", busy, 1'b1);
      check("rescan_cleared", {count_p1, count_p2, count_empty,
            format_error}, 29'd0);
      n = 0;
      while (!done && n < 400) begin
        @(posedge clock); #1;
        n++;
      end
      check("rescan_done_cycle", n + 1, 265);
      @(posedge clock); #1;
      check("rescan_counts", {count_p1, count_p2, count_empty,
            format_error}, {7'(e_p1), 7'(e_p2), 7'(e_em), e_fe});
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    cell_ready = 1'b1;
    load_pattern();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    check("reset_state", out_vec(), 64'd0);
    @(posedge clock); #1;
    check("idle_no_start", {busy, done, cell_valid}, 3'd0);

    scan(0, 0, 0, 0);
    check("pattern_p1", count_p1, 7'd2);
    check("pattern_p2", count_p2, 7'd2);
    check("pattern_empty", count_empty, 7'd60);
    check("pattern_fe", format_error, 1'b0);

    scan(1, 0, 0, 0);

    mem[0]  = 2'b00;
    mem[33] = 2'b11;
    scan(2, 0, 0, 0);
    check("err_empty", count_empty, 7'd59);
    check("err_fe", format_error, 1'b1);

    load_pattern();
    scan(0, 100, 0, 0);
    load_random(0);
    scan(2, 0, 0, 0);

    load_pattern();
    scan(2, 0, 0, 1);
    scan(0, 0, 1, 0);

    for (int k = 0; k < 3; k++) begin
      load_random(k == 2);
      scan(2, 0, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
